// File: rtl/cajero_pkg.sv
// Shared types and constants for the ATM controller: state encoding, balance/amount widths
// and the retry limit that locks the card.
package cajero_pkg;

  localparam int unsigned BALANCE_W    = 64;
  localparam int unsigned MONTO_W      = 32;
  localparam int unsigned PIN_W        = 16;
  localparam int unsigned DIGITO_W     = 4;
  localparam int unsigned MAX_INTENTOS = 3;
  localparam int unsigned FALLOS_W     = $clog2(MAX_INTENTOS + 1);

  typedef logic [BALANCE_W-1:0] balance_t;
  typedef logic [FALLOS_W-1:0]  fallos_t;

  typedef enum logic [1:0] {
    ESPERA_TARJETA = 2'd0,
    ESPERA_PIN     = 2'd1,
    ESPERA_MONTO   = 2'd2,
    BLOQUEADO      = 2'd3
  } estado_t;

  function automatic balance_t extender_monto(input logic [MONTO_W-1:0] monto);
    return {{(BALANCE_W - MONTO_W){1'b0}}, monto};
  endfunction

endpackage

// File: rtl/captura_pin.sv
// Collects four BCD digits; o_codigo/o_listo present the full entry in the same cycle the
// fourth digit is strobed so the caller can register the compare result one cycle later.
module captura_pin
  import cajero_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_habilitar,
  input  logic                i_stb,
  input  logic [DIGITO_W-1:0] i_digito,
  output logic [PIN_W-1:0]    o_codigo,
  output logic                o_listo
);

  // Only the first three digits need storage; the fourth arrives on i_digito.
  logic [PIN_W-DIGITO_W-1:0] r_digitos;
  logic [1:0]                r_cuenta;
  logic                      w_captura;

  assign w_captura = i_habilitar && i_stb;
  assign o_codigo  = {r_digitos, i_digito};
  assign o_listo   = w_captura && (r_cuenta == 2'd3);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_digitos <= '0;
      r_cuenta  <= '0;
    end else if (!i_habilitar) begin
      r_digitos <= '0;
      r_cuenta  <= '0;
    end else if (i_stb) begin
      r_digitos <= o_codigo[PIN_W-DIGITO_W-1:0];
      r_cuenta  <= r_cuenta + 2'd1;
    end
  end

endmodule

// File: rtl/cajero_automatico.sv
// ATM controller: card detect, 4-digit PIN check with lockout, deposit/withdrawal on a 64-bit
// balance. Define CAJERO_SATURACION_EN to saturate overflowing deposits instead of wrapping.
module cajero_automatico
  import cajero_pkg::*;
#(
  parameter logic [63:0] BALANCE_INICIAL = 64'd1000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                TARJETA_RECIBIDA,
  input  logic [PIN_W-1:0]    PIN,
  input  logic [DIGITO_W-1:0] DIGITO,
  input  logic                DIGITO_STB,
  input  logic                TIPO_TRANS,
  input  logic [MONTO_W-1:0]  MONTO,
  input  logic                MONTO_STB,
  output logic                BALANCE_ACTUALIZADO,
  output logic                ENTREGAR_DINERO,
  output logic                FONDOS_INSUFICIENTES,
  output logic                PIN_INCORRECTO,
  output logic                ADVERTENCIA,
  output logic                BLOQUEO
);

  estado_t    r_estado, w_estado_sig;
  balance_t   r_balance, w_balance_sig;
  fallos_t    r_fallos, w_fallos_sig, w_fallos_inc;
  logic       r_bal_act, w_bal_act_sig;
  logic       r_entregar, w_entregar_sig;
  logic       r_fondos, w_fondos_sig;
  logic       r_pin_inc, w_pin_inc_sig;
  logic       r_adv, w_adv_sig;
  logic       r_bloqueo, w_bloqueo_sig;

  logic             w_habilitar;
  logic [PIN_W-1:0] w_codigo;
  logic             w_listo;
  balance_t         w_monto_ext;
  balance_t         w_deposito;
  logic             w_alcanza;

  // Card removal has priority, so the digit collector is gated by the card level too.
  assign w_habilitar = (r_estado == ESPERA_PIN) && TARJETA_RECIBIDA;

  captura_pin u_captura_pin (
    .i_clk       (CLK),
    .i_rst_n     (RESET),
    .i_habilitar (w_habilitar),
    .i_stb       (DIGITO_STB),
    .i_digito    (DIGITO),
    .o_codigo    (w_codigo),
    .o_listo     (w_listo)
  );

  assign w_monto_ext  = extender_monto(MONTO);
  assign w_alcanza    = (w_monto_ext <= r_balance);
  assign w_fallos_inc = r_fallos + fallos_t'(1);

`ifdef CAJERO_SATURACION_EN
  logic [BALANCE_W:0] w_suma;
  assign w_suma     = {1'b0, r_balance} + {1'b0, w_monto_ext};
  assign w_deposito = w_suma[BALANCE_W] ? '1 : w_suma[BALANCE_W-1:0];
`else
  assign w_deposito = r_balance + w_monto_ext;
`endif

  always_comb begin
    w_estado_sig   = r_estado;
    w_balance_sig  = r_balance;
    w_fallos_sig   = r_fallos;
    w_adv_sig      = r_adv;
    w_bloqueo_sig  = r_bloqueo;
    w_bal_act_sig  = 1'b0;
    w_entregar_sig = 1'b0;
    w_fondos_sig   = 1'b0;
    w_pin_inc_sig  = 1'b0;

    unique case (r_estado)
      ESPERA_TARJETA: begin
        if (TARJETA_RECIBIDA) w_estado_sig = ESPERA_PIN;
      end
      ESPERA_PIN: begin
        if (!TARJETA_RECIBIDA) begin
          w_estado_sig = ESPERA_TARJETA;
        end else if (w_listo) begin
          if (w_codigo == PIN) begin
            w_fallos_sig = '0;
            w_adv_sig    = 1'b0;
            w_estado_sig = ESPERA_MONTO;
          end else begin
            w_pin_inc_sig = 1'b1;
            w_fallos_sig  = w_fallos_inc;
            if (w_fallos_inc >= fallos_t'(MAX_INTENTOS)) begin
              w_bloqueo_sig = 1'b1;
              w_estado_sig  = BLOQUEADO;
            end else if (w_fallos_inc >= fallos_t'(MAX_INTENTOS - 1)) begin
              w_adv_sig = 1'b1;
            end
          end
        end
      end
      ESPERA_MONTO: begin
        if (!TARJETA_RECIBIDA) begin
          w_estado_sig = ESPERA_TARJETA;
        end else if (MONTO_STB) begin
          w_estado_sig = ESPERA_TARJETA;
          if (!TIPO_TRANS) begin
            w_balance_sig = w_deposito;
            w_bal_act_sig = 1'b1;
          end else if (w_alcanza) begin
            w_balance_sig  = r_balance - w_monto_ext;
            w_bal_act_sig  = 1'b1;
            w_entregar_sig = 1'b1;
          end else begin
            w_fondos_sig = 1'b1;
          end
        end
      end
      BLOQUEADO: begin
        w_estado_sig = BLOQUEADO;
      end
      default: begin
        w_estado_sig = ESPERA_TARJETA;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_estado   <= ESPERA_TARJETA;
      r_balance  <= BALANCE_INICIAL;
      r_fallos   <= '0;
      r_bal_act  <= 1'b0;
      r_entregar <= 1'b0;
      r_fondos   <= 1'b0;
      r_pin_inc  <= 1'b0;
      r_adv      <= 1'b0;
      r_bloqueo  <= 1'b0;
    end else begin
      r_estado   <= w_estado_sig;
      r_balance  <= w_balance_sig;
      r_fallos   <= w_fallos_sig;
      r_bal_act  <= w_bal_act_sig;
      r_entregar <= w_entregar_sig;
      r_fondos   <= w_fondos_sig;
      r_pin_inc  <= w_pin_inc_sig;
      r_adv      <= w_adv_sig;
      r_bloqueo  <= w_bloqueo_sig;
    end
  end

  assign BALANCE_ACTUALIZADO  = r_bal_act;
  assign ENTREGAR_DINERO      = r_entregar;
  assign FONDOS_INSUFICIENTES = r_fondos;
  assign PIN_INCORRECTO       = r_pin_inc;
  assign ADVERTENCIA          = r_adv;
  assign BLOQUEO              = r_bloqueo;

endmodule

// File: tb/tb_cajero_automatico.sv
// Scoreboarded random bench for cajero_automatico: two instances (default balance and
// near-overflow balance) share stimulus; a session-level model predicts every output pulse.
module tb_cajero_automatico;

  localparam logic [63:0] INI0 = 64'd1000;
  localparam logic [63:0] INI1 = 64'hFFFF_FFFF_FFFF_FFF6;

  logic        CLK = 1'b0;
  logic        RESET, TARJETA_RECIBIDA, DIGITO_STB, TIPO_TRANS, MONTO_STB;
  logic [15:0] PIN;
  logic [3:0]  DIGITO;
  logic [31:0] MONTO;
  logic        bal0, ent0, fon0, pin0, adv0, blo0;
  logic        bal1, ent1, fon1, pin1, adv1, blo1;

  cajero_automatico #(.BALANCE_INICIAL(INI0)) dut0 (
    .CLK(CLK), .RESET(RESET), .TARJETA_RECIBIDA(TARJETA_RECIBIDA), .PIN(PIN),
    .DIGITO(DIGITO), .DIGITO_STB(DIGITO_STB), .TIPO_TRANS(TIPO_TRANS), .MONTO(MONTO),
    .MONTO_STB(MONTO_STB), .BALANCE_ACTUALIZADO(bal0), .ENTREGAR_DINERO(ent0),
    .FONDOS_INSUFICIENTES(fon0), .PIN_INCORRECTO(pin0), .ADVERTENCIA(adv0), .BLOQUEO(blo0)
  );

  cajero_automatico #(.BALANCE_INICIAL(INI1)) dut1 (
    .CLK(CLK), .RESET(RESET), .TARJETA_RECIBIDA(TARJETA_RECIBIDA), .PIN(PIN),
    .DIGITO(DIGITO), .DIGITO_STB(DIGITO_STB), .TIPO_TRANS(TIPO_TRANS), .MONTO(MONTO),
    .MONTO_STB(MONTO_STB), .BALANCE_ACTUALIZADO(bal1), .ENTREGAR_DINERO(ent1),
    .FONDOS_INSUFICIENTES(fon1), .PIN_INCORRECTO(pin1), .ADVERTENCIA(adv1), .BLOQUEO(blo1)
  );

  always #5 CLK = ~CLK;

  // flags = {BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES, PIN_INCORRECTO,
  //          ADVERTENCIA, BLOQUEO}
  typedef struct packed {
    logic [5:0]  flags;
    logic [63:0] bal;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Session-level model state
  logic [63:0] m_bal0, m_bal1;
  int          m_fallos;
  bit          m_bloq, m_auth, m_card;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic mon(input int idx, input logic [5:0] f, input logic [63:0] b);
    exp_t e;
    if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
      check($sformatf("unexpected pulse dut%0d", idx), {58'd0, f}, 64'd0);
    end else begin
      e = (idx == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("flags dut%0d", idx), {58'd0, f}, {58'd0, e.flags});
      check($sformatf("balance dut%0d", idx), b, e.bal);
    end
  endtask

  always @(negedge CLK) begin
    if (RESET === 1'b1) begin
      if (bal0 | ent0 | fon0 | pin0) mon(0, {bal0, ent0, fon0, pin0, adv0, blo0}, dut0.r_balance);
      if (bal1 | ent1 | fon1 | pin1) mon(1, {bal1, ent1, fon1, pin1, adv1, blo1}, dut1.r_balance);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] c;
    for (int i = 0; i < 4; i++) c[15-4*i -: 4] = 4'($urandom_range(0, 9));
    return c;
  endfunction

  // Outcome of one transaction on a given balance, straight from the account rules.
  task automatic outcome(input logic [63:0] bal, input bit tipo, input logic [31:0] m,
                         output logic [63:0] nb, output logic [5:0] f);
    logic [64:0] s;
    if (!tipo) begin
      s = {1'b0, bal} + {33'd0, m};
`ifdef CAJERO_SATURACION_EN
      nb = s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
`else
      nb = s[63:0];
`endif
      f = 6'b100000;
    end else if ({32'd0, m} <= bal) begin
      nb = bal - {32'd0, m};
      f  = 6'b110000;
    end else begin
      nb = bal;
      f  = 6'b001000;
    end
  endtask

  task automatic check_levels();
    check("ADVERTENCIA dut0", {63'd0, adv0}, {63'd0, m_fallos >= 2});
    check("BLOQUEO dut0", {63'd0, blo0}, {63'd0, m_bloq});
    check("ADVERTENCIA dut1", {63'd0, adv1}, {63'd0, m_fallos >= 2});
    check("BLOQUEO dut1", {63'd0, blo1}, {63'd0, m_bloq});
  endtask

  task automatic do_reset(input logic [15:0] new_pin);
    RESET = 1'b0;
    TARJETA_RECIBIDA = 1'b0;
    DIGITO_STB = 1'b0;
    MONTO_STB = 1'b0;
    #2;
    check("reset outputs dut0", {58'd0, bal0, ent0, fon0, pin0, adv0, blo0}, 64'd0);
    check("reset outputs dut1", {58'd0, bal1, ent1, fon1, pin1, adv1, blo1}, 64'd0);
    check("reset balance dut0", dut0.r_balance, INI0);
    check("reset balance dut1", dut1.r_balance, INI1);
    check("pending at reset", 64'(q0.size() + q1.size()), 64'd0);
    q0.delete();
    q1.delete();
    m_bal0 = INI0;
    m_bal1 = INI1;
    m_fallos = 0;
    m_bloq = 1'b0;
    m_auth = 1'b0;
    m_card = 1'b0;
    PIN = new_pin;
    @(negedge CLK);
    RESET = 1'b1;
    tick();
  endtask

  task automatic start_session();
    TARJETA_RECIBIDA = 1'b1;
    tick();
    m_card = 1'b1;
  endtask

  task automatic end_session();
    TARJETA_RECIBIDA = 1'b0;
    tick();
    m_card = 1'b0;
    m_auth = 1'b0;
  endtask

  task automatic enter_code(input logic [15:0] code, input int ndig);
    if (ndig == 4 && m_card && !m_auth && !m_bloq) begin
      if (code == PIN) begin
        m_auth = 1'b1;
        m_fallos = 0;
      end else begin
        m_fallos++;
        if (m_fallos >= 3) m_bloq = 1'b1;
        q0.push_back({4'b0001, m_fallos >= 2, m_bloq, m_bal0});
        q1.push_back({4'b0001, m_fallos >= 2, m_bloq, m_bal1});
      end
    end
    for (int i = 0; i < ndig; i++) begin
      DIGITO = code[15-4*i -: 4];
      DIGITO_STB = 1'b1;
      tick();
    end
    DIGITO_STB = 1'b0;
    tick();
  endtask

  task automatic transaction(input bit tipo, input logic [31:0] m);
    logic [5:0] f;
    logic [63:0] nb;
    if (m_card && m_auth && !m_bloq) begin
      outcome(m_bal0, tipo, m, nb, f);
      m_bal0 = nb;
      q0.push_back({f, nb});
      outcome(m_bal1, tipo, m, nb, f);
      m_bal1 = nb;
      q1.push_back({f, nb});
      m_auth = 1'b0;
    end
    TIPO_TRANS = tipo;
    MONTO = m;
    MONTO_STB = 1'b1;
    tick();
    MONTO_STB = 1'b0;
    tick();
  endtask

  // Card pulled in the same cycle as both strobes: nothing may happen.
  task automatic abort_strobes();
    TARJETA_RECIBIDA = 1'b0;
    MONTO_STB = 1'b1;
    MONTO = 32'd50;
    TIPO_TRANS = 1'b0;
    DIGITO_STB = 1'b1;
    DIGITO = 4'd1;
    tick();
    MONTO_STB = 1'b0;
    DIGITO_STB = 1'b0;
    m_card = 1'b0;
    m_auth = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    RESET = 1'b0;
    TARJETA_RECIBIDA = 1'b0;
    DIGITO_STB = 1'b0;
    MONTO_STB = 1'b0;
    TIPO_TRANS = 1'b0;
    DIGITO = 4'd0;
    MONTO = 32'd0;
    PIN = 16'h6575;
    repeat (2) @(posedge CLK);

    // Overflow deposit on the near-full account
    do_reset(16'h6575);
    start_session();
    enter_code(16'h6575, 4);
    transaction(1'b0, 32'd20);
    end_session();
`ifdef CAJERO_SATURACION_EN
    check("overflow deposit", dut1.r_balance, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    check("overflow deposit", dut1.r_balance, 64'd10);
`endif

    // Correct PIN then deposit 200
    do_reset(16'h6575);
    start_session();
    enter_code(16'h6575, 4);
    transaction(1'b0, 32'd200);
    end_session();
    check("deposit 200", dut0.r_balance, 64'd1200);

    // Insufficient funds, then exact withdrawal to zero
    do_reset(16'h6575);
    start_session();
    enter_code(16'h6575, 4);
    transaction(1'b1, 32'd1500);
    enter_code(16'h6575, 4);
    transaction(1'b1, 32'd1000);
    end_session();
    check("withdraw all", dut0.r_balance, 64'd0);

    // Three wrong entries lock; later correct entry and strobes ignored
    do_reset(16'h6575);
    start_session();
    enter_code(16'h6535, 4);
    check_levels();
    enter_code(16'h6533, 4);
    check_levels();
    enter_code(16'h6534, 4);
    check_levels();
    enter_code(16'h6575, 4);
    transaction(1'b0, 32'd5);
    end_session();
    check_levels();

    // Reset mid-entry, then full correct entry and zero-amount transactions
    do_reset(16'h6575);
    start_session();
    enter_code(16'h6575, 2);
    do_reset(16'h6575);
    start_session();
    enter_code(16'h6575, 4);
    transaction(1'b1, 32'd0);
    enter_code(16'h6575, 4);
    transaction(1'b0, 32'd0);
    end_session();

    // Stray strobes in the wrong states, digits with no card, simultaneous card pull
    enter_code(16'h6575, 4);
    start_session();
    transaction(1'b0, 32'd100);
    enter_code(16'h6575, 4);
    enter_code(16'h1234, 4);
    transaction(1'b0, 32'd7);
    enter_code(16'h6575, 4);
    abort_strobes();
    check_levels();

    // Fail count survives card removal; a match clears the warning
    start_session();
    enter_code(16'h1111, 4);
    end_session();
    start_session();
    enter_code(16'h2222, 4);
    end_session();
    check_levels();
    start_session();
    enter_code(16'h6575, 4);
    check_levels();
    transaction(1'b1, 32'd3);
    end_session();

    for (int it = 0; it < 200; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (m_bloq || r == 0) do_reset(rand_bcd());
      start_session();
      if (r == 1) begin
        enter_code(rand_bcd(), $urandom_range(1, 3));
        end_session();
        continue;
      end
      for (int a = 0; a < 3; a++) begin
        if (m_auth || m_bloq) break;
        enter_code(($urandom_range(0, 1) == 1) ? PIN : rand_bcd(), 4);
        if ($urandom_range(0, 4) == 0) break;
      end
      check_levels();
      if (r == 2) begin
        abort_strobes();
      end else begin
        case ($urandom_range(0, 3))
          0: transaction(1'($urandom_range(0, 1)), $urandom);
          1: transaction(1'($urandom_range(0, 1)), 32'd0);
          default: transaction(1'($urandom_range(0, 1)), 32'($urandom_range(0, 1500)));
        endcase
        end_session();
      end
      check_levels();
    end

    repeat (3) tick();
    check("queue dut0 drained", 64'(q0.size()), 64'd0);
    check("queue dut1 drained", 64'(q1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
